decode_rat_checkpoint_ctrl: RTL and testbench
=============================================

# decode_rat_checkpoint_ctrl

Allocation and retirement controller for the 4-entry RAT checkpoint store in the decode stage. It hands out checkpoint slots and 4-bit branch IDs in program order as branches are renamed, and drives the store's write port (`cp_wea`/`cp_addra`). At branch commit (BCO) it either frees the oldest line (`cp_wef`) or triggers recovery (`cp_web`/`cp_addrb`) and sequences a one-cycle restore window. It keeps occupancy consistent with the store's `valid` vector and flags protocol violations.

## Interface
Parameters: none; geometry is fixed at 4 checkpoints and a 4-bit branch ID.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `snoop_hit` in 1: flush all checkpoints; the same signal also feeds the store.
- `alloc_req` in 1: decode has a branch to checkpoint this cycle.
- `alloc_ready` out 1: a slot is available; allocation fires when `alloc_req & alloc_ready`.
- `alloc_bid` out 4: branch ID for the allocating branch, equal to `tail`.
- `cp_wea` out 1: store write enable.
- `cp_addra` out 2: store write slot.
- `bco_valid` in 1: branch commit outcome, delivered in order with commit.
- `bco_bid` in 4: ID of the committing branch.
- `bco_mispredict` in 1: the committing branch mispredicted.
- `cp_web` out 1: recovery / set-invalidate strobe to the store.
- `cp_addrb` out 2: store recovery read slot.
- `cp_wef` out 1: line-invalidate strobe on correct branch commit.
- `cp_dinf_bid` out 4: branch ID accompanying `cp_wef`.
- `cp_valid` in 4: checkpoint valid vector read back from the store.
- `recover_valid` out 1: restore window; the store's `doutb_*` is valid for RAT reload.
- `recover_bid` out 4: ID of the mispredicted branch being restored.
- `count` out 3: checkpoints in flight, 0..4.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Pointers.** `head` and `tail` are 4-bit wrapping counters. A checkpoint's slot is `bid[1:0]`. `count = tail - head` (mod 16); values above 4 are impossible by design.
- **`flush_now`** = `snoop_hit | (bco_valid & bco_mispredict & count != 0)`.
- **`alloc_ready`** = `count < 4` & state is IDLE & `~flush_now`. There is no bypass from a same-cycle commit: at `count == 4` with a commit, `alloc_ready` stays 0.
- **Allocation fire.** `cp_wea = 1` and `cp_addra = tail[1:0]`, both combinational in the same cycle. `tail` increments. Data (`dina_*`) is supplied to the store directly by the RAT.
- **Correct commit** (`bco_valid & ~bco_mispredict`, `count != 0`, `bco_bid == head`):
  - `cp_wef = 1` and `cp_dinf_bid = bco_bid`, combinational.
  - `head` increments.
  - Allocation in the same cycle is legal; both pointers move.
- **Mispredict commit** (`count != 0`, `bco_bid == head`):
  - `cp_web = 1` and `cp_addrb = head[1:0]`.
  - `rec_bid` is latched to `head`.
  - `head` is set to `tail`, giving `count = 0`.
  - State moves IDLE → RECOVER.
  - Allocation in the same cycle is suppressed.
- **RECOVER** lasts exactly 1 cycle:
  - `recover_valid = 1`, `recover_bid = rec_bid`, `cp_addrb = rec_bid[1:0]`. The store's line data survives `web`.
  - `alloc_ready = 0`.
  - The next state is always IDLE.
- **Default `cp_addrb`.** Outside RECOVER, `cp_addrb = head[1:0]`.
- **`snoop_hit`.** Sets `head` to `tail`. It does not assert `cp_web`, and it does not alter the state machine; a RECOVER in progress completes.
- **Simultaneous `snoop_hit` and BCO.** The mispredict action is still taken (`cp_web`, enter RECOVER). A correct-commit `cp_wef` is still issued. Both result in `head = tail`.
- **Errors.** Each of the following sets `err`; the offending BCO causes no state change.
  - `bco_valid` with `count == 0`.
  - `bco_bid != head`.
  - Allocation fire while `cp_valid[tail[1:0]] == 1`.
  - In IDLE with no same-cycle strobe, `cp_valid` differs from the occupancy mask implied by `head`/`count`.
- `err` is cleared only by `reset`.

## Timing
- **Reset values:** `head = tail = 0`, state IDLE, `err = 0`, `rec_bid = 0`.
- **Outputs while `reset` is asserted:** `alloc_ready` is 0 (combinationally gated). `alloc_bid = 0`, `count = 0`, `recover_valid = 0`, `recover_bid = 0`, `cp_addrb = 0`, and `cp_wea`, `cp_web`, `cp_wef` are 0.
- **Zero-latency strobes:** `cp_wea`, `cp_web`, `cp_wef` are combinational in the cycle of the triggering input.
- **Pointer update:** `count` reflects an allocation or commit in the next cycle.
- **Recovery latency:** `recover_valid` is asserted exactly 1 cycle after the mispredict BCO. `alloc_ready` is back to 1 in the cycle after that.
- **Wrap-around:** bid 15 is followed by 0. Slots reuse as 3→0, with a generation difference of 4 between successive uses of a slot.
- **Reset mid-RECOVER:** returns to IDLE immediately; no `recover_valid` pulse follows.

## Test plan
- **Fill and stall:**
  - Apply 5 consecutive `alloc_req` from reset.
  - Required: bids 0, 1, 2, 3 with `cp_addra` 0..3.
  - Required: fifth cycle `alloc_ready = 0`, `count = 4`.
- **Commit and wrap:**
  - From full, apply BCO correct bid 0 plus `alloc_req`.
  - Required: `cp_wef` with bid 0, no allocation that cycle.
  - Required: next cycle allocation gives bid 4, slot 0.
  - Continue to bid 15 → 0 wrap; required `err = 0`.
- **Mispredict:**
  - Set `count = 3` (head = 2), then apply BCO mispredict bid 2 with `alloc_req`.
  - Required: `cp_web = 1`, `cp_addrb = 2`, no `cp_wea`.
  - Required: next cycle `recover_valid = 1`, `recover_bid = 2`, `cp_addrb = 2`, `alloc_ready = 0`.
  - Required: following cycle `count = 0`, `alloc_ready = 1`.
- **Snoop:**
  - With `count = 2`, assert `snoop_hit` together with `alloc_req`.
  - Required: no `cp_wea`, `count = 0` next cycle, no `recover_valid`.
- **Errors:**
  - BCO at `count = 0` → required `err` = 1 sticky, pointers unchanged.
  - BCO with a wrong bid → required `err` = 1.
  - `cp_valid[tail]` high at allocation → required `err` = 1.
- **Reset mid-operation:**
  - Assert `reset` asynchronously during RECOVER.
  - Required: all outputs go to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/decode_rat_checkpoint_ctrl.sv
// Allocation / retirement controller for the 4-entry RAT checkpoint store.
// Hands out slots and 4-bit branch IDs in program order, frees or recovers
// the oldest checkpoint at branch commit, and flags protocol violations.
module decode_rat_checkpoint_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       snoop_hit,
  input  logic       alloc_req,
  output logic       alloc_ready,
  output logic [3:0] alloc_bid,
  output logic       cp_wea,
  output logic [1:0] cp_addra,
  input  logic       bco_valid,
  input  logic [3:0] bco_bid,
  input  logic       bco_mispredict,
  output logic       cp_web,
  output logic [1:0] cp_addrb,
  output logic       cp_wef,
  output logic [3:0] cp_dinf_bid,
  input  logic [3:0] cp_valid,
  output logic       recover_valid,
  output logic [3:0] recover_bid,
  output logic [2:0] count,
  output logic       err
);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t     state, state_nxt;
  logic [3:0] head, tail, rec_bid;
  logic [3:0] head_nxt, tail_nxt, rec_bid_nxt;
  logic [3:0] occ;
  logic [3:0] occ_mask;
  logic       nonempty, flush_now, bco_ok, err_nxt;

  // Occupancy, handshakes and zero-latency strobes to the store.
  always_comb begin
    occ           = tail - head;
    count         = occ[2:0];
    nonempty      = (occ != 4'd0);
    flush_now     = snoop_hit | (bco_valid & bco_mispredict & nonempty);
    alloc_ready   = ~reset & (occ < 4'd4) & (state == IDLE) & ~flush_now;
    cp_wea        = alloc_req & alloc_ready;
    cp_addra      = tail[1:0];
    alloc_bid     = tail;
    bco_ok        = ~reset & bco_valid & nonempty & (bco_bid == head);
    cp_wef        = bco_ok & ~bco_mispredict;
    cp_web        = bco_ok & bco_mispredict;
    cp_dinf_bid   = bco_bid;
    recover_valid = (state == RECOVER);
    recover_bid   = rec_bid;
    cp_addrb      = recover_valid ? rec_bid[1:0] : head[1:0];
  end

  // Slots expected valid in the store: head[1:0] .. head[1:0]+count-1 (mod 4).
  always_comb begin
    occ_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      logic [1:0] off;
      off = 2'(i) - head[1:0];
      occ_mask[i] = ({1'b0, off} < count);
    end
  end

  // Next-state, pointer moves and sticky error detection.
  always_comb begin
    state_nxt   = IDLE;
    head_nxt    = head;
    tail_nxt    = tail + {3'b000, cp_wea};
    rec_bid_nxt = rec_bid;
    case (state)
      IDLE:    state_nxt = cp_web ? RECOVER : IDLE;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A flush (snoop or mispredict) empties the ring; allocation is blocked
    // that cycle, so the current tail is the right target for head.
    if (snoop_hit | cp_web)
      head_nxt = tail;
    else if (cp_wef)
      head_nxt = head + 4'd1;
    if (cp_web)
      rec_bid_nxt = head;
    err_nxt = err
            | (bco_valid & ~nonempty)
            | (bco_valid & (bco_bid != head))
            | (cp_wea & cp_valid[tail[1:0]])
            | ((state == IDLE) & ~cp_wea & ~cp_web & ~cp_wef & (cp_valid != occ_mask));
  end

  // State and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      rec_bid <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      head    <= head_nxt;
      tail    <= tail_nxt;
      rec_bid <= rec_bid_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_decode_rat_checkpoint_ctrl.sv
// Self-checking bench for decode_rat_checkpoint_ctrl with a ring-buffer
// reference model and a model of the checkpoint store's valid vector.
module tb_decode_rat_checkpoint_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       snoop_hit = 1'b0, alloc_req = 1'b0;
  logic       alloc_ready, cp_wea, cp_web, cp_wef, recover_valid, err;
  logic [3:0] alloc_bid, cp_dinf_bid, recover_bid;
  logic [1:0] cp_addra, cp_addrb;
  logic       bco_valid = 1'b0, bco_mispredict = 1'b0;
  logic [3:0] bco_bid = '0, cp_valid = '0;
  logic [2:0] count;

  int passed = 0;
  int total  = 0;

  // Reference state: pointers as plain integers mod 16, store valid bits.
  int   mh, mt, mrb;
  bit   mrec, merr;
  logic [3:0] mv;

  always #5 clk = ~clk;

  decode_rat_checkpoint_ctrl dut (
    .clk(clk), .reset(reset), .snoop_hit(snoop_hit), .alloc_req(alloc_req),
    .alloc_ready(alloc_ready), .alloc_bid(alloc_bid), .cp_wea(cp_wea),
    .cp_addra(cp_addra), .bco_valid(bco_valid), .bco_bid(bco_bid),
    .bco_mispredict(bco_mispredict), .cp_web(cp_web), .cp_addrb(cp_addrb),
    .cp_wef(cp_wef), .cp_dinf_bid(cp_dinf_bid), .cp_valid(cp_valid),
    .recover_valid(recover_valid), .recover_bid(recover_bid),
    .count(count), .err(err)
  );

  // Layout: [24]rdy [23:20]abid [19]wea [18:17]addra [16]web [15:14]addrb
  //         [13]wef [12:9]dinf [8]rv [7:4]rbid [3:1]count [0]err
  function automatic logic [24:0] act_vec();
    return {alloc_ready, alloc_bid, cp_wea, cp_wea ? cp_addra : 2'b00, cp_web,
            cp_addrb, cp_wef, cp_wef ? cp_dinf_bid : 4'h0, recover_valid,
            recover_bid, count, err};
  endfunction

  task automatic model_reset();
    mh = 0; mt = 0; mrb = 0; mrec = 0; merr = 0; mv = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; alloc_req = 0; bco_valid = 0; bco_mispredict = 0;
    snoop_hit = 0; bco_bid = '0; cp_valid = '0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One cycle: drive inputs at posedge+1, capture expected/actual at
  // posedge+4, then advance the model across the edge.
  task automatic step(input logic req, input logic bv, input logic mp,
                      input logic snp, input logic [3:0] bid,
                      input logic [3:0] vflip,
                      output logic [24:0] ev, output logic [24:0] av);
    int cnt, oldt;
    bit flush, rdy, fire, ok, wef, web, e;
    logic [3:0] mask;
    alloc_req = req; bco_valid = bv; bco_mispredict = mp; snoop_hit = snp;
    bco_bid = bid; cp_valid = mv ^ vflip;
    #3;
    cnt   = (mt - mh) & 15;
    flush = snp || (bv && mp && cnt != 0);
    rdy   = (cnt < 4) && !mrec && !flush;
    fire  = req && rdy;
    ok    = bv && cnt != 0 && int'(bid) == mh;
    wef   = ok && !mp;
    web   = ok && mp;
    mask  = '0;
    for (int k = 0; k < cnt; k++) mask[(mh + k) & 3] = 1'b1;
    ev = {rdy, 4'(mt), fire, fire ? 2'(mt) : 2'b00, web,
          mrec ? 2'(mrb) : 2'(mh), wef, wef ? bid : 4'h0, mrec, 4'(mrb),
          3'(cnt), merr};
    av = act_vec();
    e = (bv && cnt == 0) || (bv && int'(bid) != mh) ||
        (fire && cp_valid[mt & 3]) ||
        (!mrec && !fire && !web && !wef && cp_valid != mask);
    @(posedge clk); #1;
    merr = merr | e;
    if (web) mrb = mh;
    mrec = web;
    oldt = mt;
    if (snp || web) mh = mt;
    else if (wef) mh = (mh + 1) & 15;
    mt = (mt + int'(fire)) & 15;
    if (snp || web) mv = '0;
    else if (wef) mv[bid[1:0]] = 1'b0;
    if (fire) mv[oldt & 3] = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] ev, av;
    reset = 1'b1; #2;
    total++;
    if (act_vec() !== 25'd0) $display("FAIL reset_outputs actual=%h required=%h", act_vec(), 25'd0);
    else passed++;
    do_reset();
    step(0, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev) $display("FAIL reset_idle actual=%h required=%h", av, ev); else passed++;
  endtask

  task automatic test_fill_stall();
    logic [24:0] ev, av;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
      total++;
      if (av !== ev) $display("FAIL fill_vec%0d actual=%h required=%h", i, av, ev); else passed++;
      if (i < 4) begin
        total++;
        if (av[23:19] !== {4'(i), 1'b1} || av[18:17] !== 2'(i))
          $display("FAIL fill_bid%0d actual=bid%h wea%b slot%h required=bid%h slot%h",
                   i, av[23:20], av[19], av[18:17], 4'(i), 2'(i));
        else passed++;
      end else begin
        total++;
        if (av[24] !== 1'b0 || av[3:1] !== 3'd4)
          $display("FAIL fill_stall actual=rdy%b cnt%0d required=rdy0 cnt4", av[24], av[3:1]);
        else passed++;
      end
    end
  endtask

  task automatic test_commit_wrap();
    logic [24:0] ev, av;
    step(1, 1, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[13] !== 1'b1 || av[12:9] !== 4'h0 || av[19] !== 1'b0)
      $display("FAIL commit_bid0 actual=%h required=%h", av, ev);
    else passed++;
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[23:20] !== 4'h4 || av[18:17] !== 2'd0 || av[19] !== 1'b1)
      $display("FAIL commit_alloc4 actual=%h required=%h", av, ev);
    else passed++;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0, 4'(mh), 4'h0, ev, av);
      total++;
      if (av !== ev) $display("FAIL wrap_vec%0d actual=%h required=%h", i, av, ev); else passed++;
    end
    total++;
    if (err !== 1'b0) $display("FAIL wrap_err actual=%b required=0", err); else passed++;
  endtask

  task automatic test_mispredict();
    logic [24:0] ev, av;
    do_reset();
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    step(0, 1, 0, 0, 4'h0, 4'h0, ev, av);
    step(0, 1, 0, 0, 4'h1, 4'h0, ev, av);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    step(1, 1, 1, 0, 4'h2, 4'h0, ev, av);
    total++;
    if (av !== ev || av[3:1] !== 3'd3 || av[16] !== 1'b1 || av[15:14] !== 2'd2 || av[19] !== 1'b0)
      $display("FAIL mispredict_strobe actual=%h required=%h", av, ev);
    else passed++;
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[8] !== 1'b1 || av[7:4] !== 4'h2 || av[15:14] !== 2'd2 || av[24] !== 1'b0)
      $display("FAIL mispredict_recover actual=%h required=%h", av, ev);
    else passed++;
    step(0, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[3:1] !== 3'd0 || av[24] !== 1'b1 || av[8] !== 1'b0)
      $display("FAIL mispredict_after actual=%h required=%h", av, ev);
    else passed++;
  endtask

  task automatic test_snoop();
    logic [24:0] ev, av;
    do_reset();
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    step(1, 0, 0, 1, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[19] !== 1'b0 || av[3:1] !== 3'd2)
      $display("FAIL snoop_noalloc actual=%h required=%h", av, ev);
    else passed++;
    step(0, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[3:1] !== 3'd0 || av[8] !== 1'b0)
      $display("FAIL snoop_after actual=%h required=%h", av, ev);
    else passed++;
  endtask

  task automatic test_errors();
    logic [24:0] ev, av;
    do_reset();
    step(0, 1, 0, 0, 4'h0, 4'h0, ev, av);
    step(0, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[0] !== 1'b1 || av[3:1] !== 3'd0 || av[23:20] !== 4'h0)
      $display("FAIL err_empty_bco actual=%h required=%h", av, ev);
    else passed++;
    step(0, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av[0] !== 1'b1) $display("FAIL err_sticky actual=%b required=1", av[0]); else passed++;
    do_reset();
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    step(0, 1, 0, 0, 4'h3, 4'h0, ev, av);
    step(0, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[0] !== 1'b1 || av[3:1] !== 3'd1)
      $display("FAIL err_wrong_bid actual=%h required=%h", av, ev);
    else passed++;
    do_reset();
    step(1, 0, 0, 0, 4'h0, 4'b0001, ev, av);
    step(0, 0, 0, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (av !== ev || av[0] !== 1'b1)
      $display("FAIL err_alloc_valid actual=%h required=%h", av, ev);
    else passed++;
  endtask

  task automatic test_reset_mid_recover();
    logic [24:0] ev, av;
    do_reset();
    step(1, 0, 0, 0, 4'h0, 4'h0, ev, av);
    step(0, 1, 1, 0, 4'h0, 4'h0, ev, av);
    total++;
    if (recover_valid !== 1'b1) $display("FAIL midrec_enter actual=%b required=1", recover_valid);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (act_vec() !== 25'd0) $display("FAIL midrec_reset actual=%h required=%h", act_vec(), 25'd0);
    else passed++;
    model_reset();
    @(posedge clk); #1;
    total++;
    if (recover_valid !== 1'b0) $display("FAIL midrec_nopulse actual=%b required=0", recover_valid);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [24:0] ev, av;
    logic [3:0] bid, vf;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bid = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'(mh);
      vf  = ($urandom_range(0, 79) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 24) == 0),
           bid, vf, ev, av);
      total++;
      if (av !== ev) $display("FAIL random_vec%0d actual=%h required=%h", i, av, ev); else passed++;
      if (i == 300) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_stall();
    test_commit_wrap();
    test_mispredict();
    test_snoop();
    test_errors();
    test_reset_mid_recover();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
